// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache definitions: memory arbiter state encoding
// and the block size used by the fill controllers.
package cache_mem_arbiter_pkg;

  localparam int WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT_I = 2'b01,
    ARB_GRANT_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the unified memory between I-cache and D-cache fills,
// passing D-cache write-through stores when the port is free.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = cache_mem_arbiter_pkg::WORDS_PER_BLOCK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_MemRead,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  dc_MemRead,
  input  logic                  dc_MemWrite,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_write_data,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  ic_MemDataValid,
  output logic                  dc_MemDataValid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  ic_wait,
  output logic                  dc_wait
);

  localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(WORDS_PER_BLOCK);

  arb_state_t    state, state_d;
  logic [CW-1:0] rcv_cnt, rcv_cnt_d;
  logic          last_grant, last_grant_d;

  logic wr_eff;
  logic en_c;
  logic ic_v;
  logic dc_v;

  // A write while dc_MemRead is high targets the cache array only.
  assign wr_eff = dc_MemWrite & ~dc_MemRead;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      rcv_cnt    <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_d;
      rcv_cnt    <= rcv_cnt_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    rcv_cnt_d    = rcv_cnt;
    last_grant_d = last_grant;
    en_c         = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = dc_addr;
    mem_data_in  = dc_write_data;
    ic_v         = 1'b0;
    dc_v         = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        en_c   = wr_eff;
        mem_wr = wr_eff;
        // Ties go to whoever was not granted last.
        if (!wr_eff) begin
          if (ic_MemRead && (!dc_MemRead || !last_grant)) begin
            state_d      = ARB_GRANT_I;
            rcv_cnt_d    = '0;
            last_grant_d = 1'b1;
          end else if (dc_MemRead) begin
            state_d      = ARB_GRANT_D;
            rcv_cnt_d    = '0;
            last_grant_d = 1'b0;
          end
        end
      end
      ARB_GRANT_I: begin
        en_c     = ic_MemRead;
        mem_addr = ic_addr;
        ic_v     = mem_data_valid;
        if (mem_data_valid && rcv_cnt != FULL_CNT)
          rcv_cnt_d = rcv_cnt + CW'(1);
        if (!ic_MemRead ||
            (mem_data_valid && rcv_cnt == LAST_WORD))
          state_d = ARB_IDLE;
      end
      ARB_GRANT_D: begin
        en_c     = dc_MemRead;
        mem_addr = dc_addr;
        dc_v     = mem_data_valid;
        if (mem_data_valid && rcv_cnt != FULL_CNT)
          rcv_cnt_d = rcv_cnt + CW'(1);
        if (!dc_MemRead ||
            (mem_data_valid && rcv_cnt == LAST_WORD))
          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Strobes are held off while reset is asserted.
  assign mem_enable      = rst & en_c;
  assign ic_MemDataValid = rst & ic_v;
  assign dc_MemDataValid = rst & dc_v;
  assign fill_data       = mem_data_out;

  assign ic_wait = ic_MemRead & (state != ARB_GRANT_I);
  assign dc_wait = (dc_MemRead & (state != ARB_GRANT_D)) |
                   (wr_eff & (state != ARB_IDLE));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus random
// traffic against an ownership/word-count reference model.
module tb_cache_mem_arbiter;

  localparam int WPB = 8;

  logic        clk;
  logic        rst;
  logic        ic_MemRead;
  logic [15:0] ic_addr;
  logic        dc_MemRead;
  logic        dc_MemWrite;
  logic [15:0] dc_addr;
  logic [15:0] dc_write_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        ic_MemDataValid;
  logic        dc_MemDataValid;
  logic [15:0] fill_data;
  logic        ic_wait;
  logic        dc_wait;

  int n_checks = 0;
  int n_errors = 0;

  cache_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ic_MemRead     (ic_MemRead),
    .ic_addr        (ic_addr),
    .dc_MemRead     (dc_MemRead),
    .dc_MemWrite    (dc_MemWrite),
    .dc_addr        (dc_addr),
    .dc_write_data  (dc_write_data),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .ic_MemDataValid(ic_MemDataValid),
    .dc_MemDataValid(dc_MemDataValid),
    .fill_data      (fill_data),
    .ic_wait        (ic_wait),
    .dc_wait        (dc_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port (0 none, 1 I, 2 D),
  // words delivered to the owner, and whether I won last.
  int m_own = 0;
  int m_got = 0;
  bit m_last_i = 1'b1;

  always @(posedge clk) begin
    if (!rst) begin
      m_own = 0;
      m_got = 0;
      m_last_i = 1'b1;
    end else if (m_own == 0) begin
      if (!(dc_MemWrite && !dc_MemRead)) begin
        if (ic_MemRead && dc_MemRead) m_own = m_last_i ? 2 : 1;
        else if (ic_MemRead) m_own = 1;
        else if (dc_MemRead) m_own = 2;
        if (m_own != 0) begin
          m_last_i = (m_own == 1);
          m_got = 0;
        end
      end
    end else begin
      if (mem_data_valid && m_got < WPB) m_got = m_got + 1;
      if (!((m_own == 1) ? ic_MemRead : dc_MemRead) ||
          (mem_data_valid && m_got == WPB))
        m_own = 0;
    end
  end

  logic        e_en, e_wr, e_icv, e_dcv, e_icw, e_dcw;
  logic [15:0] e_addr, e_wd;
  logic        e_wreff;

  always_comb begin
    e_wreff = dc_MemWrite && !dc_MemRead;
    e_en = 1'b0;
    e_wr = 1'b0;
    e_addr = dc_addr;
    e_wd = dc_write_data;
    e_icv = 1'b0;
    e_dcv = 1'b0;
    if (m_own == 0) begin
      e_en = e_wreff;
      e_wr = e_wreff;
    end else if (m_own == 1) begin
      e_en = ic_MemRead;
      e_addr = ic_addr;
      e_icv = mem_data_valid;
    end else begin
      e_en = dc_MemRead;
      e_icv = 1'b0;
      e_dcv = mem_data_valid;
    end
    if (!rst) begin
      e_en = 1'b0;
      e_icv = 1'b0;
      e_dcv = 1'b0;
    end
    e_icw = ic_MemRead && m_own != 1;
    e_dcw = (dc_MemRead && m_own != 2) || (e_wreff && m_own != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_MemRead = 1'b0;
    ic_addr = '0;
    dc_MemRead = 1'b0;
    dc_MemWrite = 1'b0;
    dc_addr = '0;
    dc_write_data = '0;
    mem_data_out = '0;
    mem_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) begin
      tick();
      #3;
      n_checks++;
      if ({mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait} !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_hold got %b want 00000",
                 {mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait});
      end
    end
    tick();
    rst = 1'b1;
    tick();
    #3;
    n_checks++;
    if ({mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_idle got %b want 00000",
               {mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait});
    end
  endtask

  task automatic test_lone_i();
    int got;
    got = 0;
    ic_MemRead = 1'b1;
    ic_addr = 16'h0040;
    #3;
    n_checks++;
    if ({mem_enable, ic_wait, dc_wait} !== 3'b010) begin
      n_errors++;
      $display("FAIL lone_i_bubble got %b want 010", {mem_enable, ic_wait, dc_wait});
    end
    tick();
    for (int cyc = 0; cyc < 100 && got < WPB; cyc++) begin
      mem_data_valid = ($urandom_range(0, 2) != 0);
      mem_data_out = 16'($urandom);
      ic_addr = 16'h0040 + 16'(got);
      #3;
      n_checks++;
      if ({mem_enable, mem_wr, ic_wait, ic_MemDataValid, dc_MemDataValid} !==
          {1'b1, 1'b0, 1'b0, mem_data_valid, 1'b0}) begin
        n_errors++;
        $display("FAIL lone_i_grant got %b want %b",
                 {mem_enable, mem_wr, ic_wait, ic_MemDataValid, dc_MemDataValid},
                 {1'b1, 1'b0, 1'b0, mem_data_valid, 1'b0});
      end
      n_checks++;
      if (mem_addr !== ic_addr || fill_data !== mem_data_out) begin
        n_errors++;
        $display("FAIL lone_i_addr got %h/%h want %h/%h",
                 mem_addr, fill_data, ic_addr, mem_data_out);
      end
      if (mem_data_valid) got++;
      tick();
    end
    n_checks++;
    if (got != WPB) begin
      n_errors++;
      $display("FAIL lone_i_timeout got %0d want %0d words", got, WPB);
    end
    mem_data_valid = 1'b0;
    #3;
    n_checks++;
    if ({mem_enable, ic_wait} !== 2'b01) begin
      n_errors++;
      $display("FAIL lone_i_release got %b want 01", {mem_enable, ic_wait});
    end
    ic_MemRead = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int got;
    int own;
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    ic_MemRead = 1'b1;
    dc_MemRead = 1'b1;
    ic_addr = 16'h0100;
    dc_addr = 16'h0200;
    #3;
    n_checks++;
    if ({mem_enable, ic_wait, dc_wait} !== 3'b011) begin
      n_errors++;
      $display("FAIL sim_bubble got %b want 011", {mem_enable, ic_wait, dc_wait});
    end
    tick();
    // D first, then I (D re-requests alongside), then D again
    for (int ph = 0; ph < 3; ph++) begin
      own = (ph == 1) ? 1 : 2;
      got = 0;
      for (int cyc = 0; cyc < 100 && got < WPB; cyc++) begin
        mem_data_valid = ($urandom_range(0, 2) != 0);
        mem_data_out = 16'($urandom);
        ic_addr = 16'($urandom);
        dc_addr = 16'($urandom);
        #3;
        n_checks++;
        if ({mem_enable, mem_wr, ic_wait, dc_wait, ic_MemDataValid, dc_MemDataValid} !==
            {1'b1, 1'b0, ic_MemRead && own != 1, dc_MemRead && own != 2,
             own == 1 && mem_data_valid, own == 2 && mem_data_valid}) begin
          n_errors++;
          $display("FAIL sim_phase%0d got %b (en wr icw dcw icv dcv)", ph,
                   {mem_enable, mem_wr, ic_wait, dc_wait, ic_MemDataValid, dc_MemDataValid});
        end
        n_checks++;
        if (mem_addr !== ((own == 1) ? ic_addr : dc_addr)) begin
          n_errors++;
          $display("FAIL sim_addr%0d got %h want %h", ph, mem_addr,
                   (own == 1) ? ic_addr : dc_addr);
        end
        if (mem_data_valid) got++;
        tick();
      end
      n_checks++;
      if (got != WPB) begin
        n_errors++;
        $display("FAIL sim_timeout%0d got %0d want %0d words", ph, got, WPB);
      end
      mem_data_valid = 1'b0;
      if (ph == 1) ic_MemRead = 1'b0;
      if (ph == 2) dc_MemRead = 1'b0;
      #3;
      n_checks++;
      if ({mem_enable, ic_wait, dc_wait} !== {1'b0, ic_MemRead, dc_MemRead}) begin
        n_errors++;
        $display("FAIL sim_gap%0d got %b want %b", ph,
                 {mem_enable, ic_wait, dc_wait}, {1'b0, ic_MemRead, dc_MemRead});
      end
      tick();
    end
  endtask

  task automatic test_write_pass();
    dc_MemWrite = 1'b1;
    dc_addr = 16'h1234;
    dc_write_data = 16'hBEEF;
    #3;
    n_checks++;
    if ({mem_enable, mem_wr, dc_wait} !== 3'b110 ||
        mem_addr !== 16'h1234 || mem_data_in !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL wr_pass got %b %h %h want 110 1234 beef",
               {mem_enable, mem_wr, dc_wait}, mem_addr, mem_data_in);
    end
    tick();
    ic_MemRead = 1'b1;
    ic_addr = 16'h0ABC;
    dc_addr = 16'h2468;
    #3;
    n_checks++;
    if ({mem_enable, mem_wr, ic_wait, dc_wait} !== 4'b1110 || mem_addr !== 16'h2468) begin
      n_errors++;
      $display("FAIL wr_prec got %b %h want 1110 2468",
               {mem_enable, mem_wr, ic_wait, dc_wait}, mem_addr);
    end
    tick();
    dc_MemWrite = 1'b0;
    #3;
    n_checks++;
    if ({mem_enable, ic_wait} !== 2'b01) begin
      n_errors++;
      $display("FAIL wr_then_bubble got %b want 01", {mem_enable, ic_wait});
    end
    tick();
    #3;
    n_checks++;
    if ({mem_enable, ic_wait} !== 2'b10 || mem_addr !== 16'h0ABC) begin
      n_errors++;
      $display("FAIL wr_then_grant got %b %h want 10 0abc", {mem_enable, ic_wait}, mem_addr);
    end
    ic_MemRead = 1'b0;
    tick();
  endtask

  task automatic test_blocked_write();
    ic_MemRead = 1'b1;
    ic_addr = 16'h0300;
    tick();
    dc_MemWrite = 1'b1;
    dc_addr = 16'h0777;
    dc_write_data = 16'h5A5A;
    for (int k = 0; k < WPB; k++) begin
      mem_data_valid = 1'b1;
      mem_data_out = 16'($urandom);
      #3;
      n_checks++;
      if ({mem_enable, mem_wr, dc_wait, ic_MemDataValid} !== 4'b1011) begin
        n_errors++;
        $display("FAIL blk_wr%0d got %b want 1011", k,
                 {mem_enable, mem_wr, dc_wait, ic_MemDataValid});
      end
      tick();
    end
    mem_data_valid = 1'b0;
    ic_MemRead = 1'b0;
    #3;
    n_checks++;
    if ({mem_enable, mem_wr, dc_wait} !== 3'b110 ||
        mem_addr !== 16'h0777 || mem_data_in !== 16'h5A5A) begin
      n_errors++;
      $display("FAIL blk_wr_issue got %b %h %h want 110 0777 5a5a",
               {mem_enable, mem_wr, dc_wait}, mem_addr, mem_data_in);
    end
    tick();
    dc_MemRead = 1'b1;
    dc_addr = 16'h0800;
    #3;
    n_checks++;
    if ({mem_enable, dc_wait} !== 2'b01) begin
      n_errors++;
      $display("FAIL fillwr_bubble got %b want 01", {mem_enable, dc_wait});
    end
    tick();
    for (int k = 0; k < WPB; k++) begin
      mem_data_valid = 1'b1;
      #3;
      n_checks++;
      if ({mem_enable, mem_wr, dc_wait, dc_MemDataValid} !== 4'b1001) begin
        n_errors++;
        $display("FAIL fillwr_mask%0d got %b want 1001", k,
                 {mem_enable, mem_wr, dc_wait, dc_MemDataValid});
      end
      tick();
    end
    mem_data_valid = 1'b0;
    dc_MemRead = 1'b0;
    dc_MemWrite = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    ic_MemRead = 1'b1;
    ic_addr = 16'h0040;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_data_valid = 1'b1;
      tick();
    end
    rst = 1'b0;
    #3;
    n_checks++;
    if ({mem_enable, ic_MemDataValid, dc_MemDataValid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_hold got %b want 000",
               {mem_enable, ic_MemDataValid, dc_MemDataValid});
    end
    tick();
    rst = 1'b1;
    ic_MemRead = 1'b0;
    #3;
    n_checks++;
    if ({mem_enable, ic_MemDataValid, dc_MemDataValid} !== 3'b000 ||
        dut.rcv_cnt !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_stray got %b cnt %0d want 000 cnt 0",
               {mem_enable, ic_MemDataValid, dc_MemDataValid}, dut.rcv_cnt);
    end
    tick();
    mem_data_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_traffic();
    int ic_got;
    int dc_got;
    ic_got = 0;
    dc_got = 0;
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!ic_MemRead) begin
        if ($urandom_range(0, 5) == 0) begin
          ic_MemRead = 1'b1;
          ic_got = 0;
        end
      end else if (ic_got >= WPB || $urandom_range(0, 63) == 0) begin
        ic_MemRead = 1'b0;
      end
      if (!dc_MemRead) begin
        if ($urandom_range(0, 5) == 0) begin
          dc_MemRead = 1'b1;
          dc_got = 0;
        end
      end else if (dc_got >= WPB || $urandom_range(0, 63) == 0) begin
        dc_MemRead = 1'b0;
      end
      dc_MemWrite = ($urandom_range(0, 3) == 0);
      ic_addr = 16'($urandom);
      dc_addr = 16'($urandom);
      dc_write_data = 16'($urandom);
      mem_data_out = 16'($urandom);
      mem_data_valid = 1'($urandom_range(0, 1));
      rst = (cyc % 150 != 149);
      #3;
      n_checks++;
      if ({mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait} !==
          {e_en, e_icv, e_dcv, e_icw, e_dcw}) begin
        n_errors++;
        $display("FAIL rnd_ctl cyc %0d got %b want %b", cyc,
                 {mem_enable, ic_MemDataValid, dc_MemDataValid, ic_wait, dc_wait},
                 {e_en, e_icv, e_dcv, e_icw, e_dcw});
      end
      if (e_en) begin
        n_checks++;
        if (mem_wr !== e_wr || mem_addr !== e_addr ||
            (e_wr && mem_data_in !== e_wd)) begin
          n_errors++;
          $display("FAIL rnd_port cyc %0d got %b %h %h want %b %h %h", cyc,
                   mem_wr, mem_addr, mem_data_in, e_wr, e_addr, e_wd);
        end
      end
      n_checks++;
      if (fill_data !== mem_data_out) begin
        n_errors++;
        $display("FAIL rnd_fill cyc %0d got %h want %h", cyc, fill_data, mem_data_out);
      end
      if (e_icv) ic_got++;
      if (e_dcv) dc_got++;
      tick();
    end
    rst = 1'b1;
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lone_i();
    test_simultaneous();
    test_write_pass();
    test_blocked_write();
    test_reset_mid_fill();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache fill controllers and upstream of the single shared multicycle unified memory.
- Grants the memory port to one cache for a complete 8-word block fill, forwards that cache's word addresses, and routes returned data and valid strobes back to it.
- Passes D-cache write-through stores to memory when no fill owns the port.

Parameters:
- ADDR_WIDTH, 16, address width.
- DATA_WIDTH, 16, data word width.
- WORDS_PER_BLOCK, 8, words returned per fill; the grant is released after this count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ic_MemRead  in  1  I-cache fill request; held high for the whole fill.
- ic_addr  in  ADDR_WIDTH  I-cache fill word address.
- dc_MemRead  in  1  D-cache fill request; held high for the whole fill.
- dc_MemWrite  in  1  D-cache write request.
- dc_addr  in  ADDR_WIDTH  D-cache fill or write address.
- dc_write_data  in  DATA_WIDTH  D-cache store data.
- mem_data_out  in  DATA_WIDTH  memory read data.
- mem_data_valid  in  1  memory read data valid.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data_in  out  DATA_WIDTH  memory write data.
- ic_MemDataValid  out  1  valid strobe routed to the I-cache.
- dc_MemDataValid  out  1  valid strobe routed to the D-cache.
- fill_data  out  DATA_WIDTH  mem_data_out, broadcast to both caches.
- ic_wait  out  1  I-cache request pending but not granted.
- dc_wait  out  1  D-cache request or write blocked.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D; registered 2-bit state. Also registered: rcv_cnt (log2(WORDS_PER_BLOCK)+1 bits) and last_grant (1 bit, 0 = D).
- Reset (rst==0 at edge): state=IDLE, rcv_cnt=0, last_grant=I, so the first tie goes to D.
- Reset effect on outputs: mem_enable=0, ic_MemDataValid=0, dc_MemDataValid=0.
- Reset effect on wait outputs: ic_wait and dc_wait follow the combinational rules below.
- Reset mid-fill: the fill is abandoned. mem_data_valid pulses arriving in IDLE are dropped and never forwarded.
- Effective D write: dc_MemWrite & ~dc_MemRead. A write asserted while dc_MemRead is high is a fill write into the cache array and is never sent to memory.
- IDLE, effective D write:
  - mem_enable=1, mem_wr=1, mem_addr=dc_addr, mem_data_in=dc_write_data, same cycle (combinational).
  - dc_wait=0, state stays IDLE.
  - Writes take precedence over starting any fill that cycle.
- IDLE, read requests with no effective write:
  - One request only: grant that requester.
  - Both requests: grant the requester that was not last_grant.
  - Next state is GRANT_I or GRANT_D; rcv_cnt is cleared; last_grant is updated.
  - The IDLE cycle is an arbitration bubble: mem_enable=0 for reads, and both wait outputs reflect their requests.
- GRANT_X:
  - mem_enable = X_MemRead, mem_wr=0, mem_addr = X_addr.
  - X_MemDataValid = mem_data_valid; the other cache's valid strobe is 0.
  - rcv_cnt increments on each mem_data_valid.
- GRANT_X exit:
  - When mem_data_valid arrives with rcv_cnt==WORDS_PER_BLOCK-1, go to IDLE at the next edge.
  - If X_MemRead drops early, also go to IDLE; late valids are then dropped.
- Wait outputs:
  - ic_wait = ic_MemRead & (state!=GRANT_I).
  - dc_wait = (dc_MemRead & state!=GRANT_D) | (effective write & state!=IDLE).
- fill_data = mem_data_out, unregistered.
- rcv_cnt saturates at WORDS_PER_BLOCK and never wraps.
- When mem_enable=0, mem_addr and mem_data_in are don't-care; the bench must not check them.

Decomposition:
- Shared cache package holds:
  - state encoding constants ARB_IDLE=2'b00, ARB_GRANT_I=2'b01, ARB_GRANT_D=2'b10;
  - WORDS_PER_BLOCK=8, shared with the fill FSM.
- No sub-module: one state register, one counter, one output mux.

Test Plan:
- Reset/idle: rst=0 for 2 cycles, then both requests low → mem_enable=0, both valids 0, both waits 0.
- Lone I fill at 0x0040:
  - Wait: ic_wait=1 for one cycle, then state GRANT_I and mem_addr follows ic_addr.
  - Data: eight mem_data_valid pulses → eight ic_MemDataValid pulses, dc_MemDataValid=0; IDLE after the 8th.
- Simultaneous fills right after reset:
  - D is granted first; ic_wait=1 throughout the D fill.
  - I is granted after the D fill's 8th valid plus one bubble cycle.
  - A second simultaneous pair then goes to I first (alternation).
- Write pass-through in IDLE: dc_MemWrite=1, dc_addr=0x1234, data 0xBEEF → same cycle mem_enable=1, mem_wr=1, mem_addr=0x1234, mem_data_in=0xBEEF, dc_wait=0.
- Blocked write and fill-write masking:
  - dc_MemWrite during GRANT_I → dc_wait=1, mem_wr=0; the write issues in the first IDLE cycle.
  - During GRANT_D with dc_MemRead=dc_MemWrite=1, mem_wr must stay 0.
- Reset mid-fill: rst=0 after the 3rd valid of an I fill → IDLE next cycle, rcv_cnt=0; a later stray mem_data_valid produces no ic_ or dc_MemDataValid.
